// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - six-slot sprite list rasteriser driving a VGA adapter write port
//
// Ports:
//   CLOCK_50     system clock, rising edge
//   reset        synchronous active-high reset
//   frame_start  one-cycle request to render the latched sprite list (honoured in IDLE only)
//   inputs[29:0] six 5-bit sprite codes, slot k at [5k+4:5k]; code[4:3] size, code[2:0] colour
//   pos[101:0]   six 17-bit positions, slot k at [17k+16:17k]; [16:8] x, [7:0] y
//   x, y, colour pixel write data, valid while plot is high, held otherwise
//   plot         pixel write strobe
//   busy         frame in progress (SETUP/DRAW)
//   done         one-cycle end-of-frame pulse
module sprite_plotter (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         frame_start,
    input  logic [29:0]  inputs,
    input  logic [101:0] pos,
    output logic [8:0]   x,
    output logic [7:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;

    state_t        state_q, state_d;
    logic [29:0]   inputs_q, inputs_d;
    logic [101:0]  pos_q, pos_d;
    logic [2:0]    slot_q, slot_d;
    logic [3:0]    cx_q, cx_d, cy_q, cy_d;
    logic [3:0]    wm1_q, wm1_d, hm1_q, hm1_d;
    logic [8:0]    x0_q, x0_d;
    logic [7:0]    y0_q, y0_d;
    logic [2:0]    col_q, col_d;
    logic [8:0]    xh_q, xh_d;
    logic [7:0]    yh_q, yh_d;
    logic [2:0]    ch_q, ch_d;

    logic [4:0]    cur_code;
    logic [16:0]   cur_pos;
    logic [9:0]    xs;
    logic [8:0]    ys;
    logic          on_screen;

    // Current slot's latched code and position.
    always_comb begin
        cur_code = inputs_q[4:0];
        cur_pos  = pos_q[16:0];
        case (slot_q)
            3'd1: begin cur_code = inputs_q[9:5];   cur_pos = pos_q[33:17];  end
            3'd2: begin cur_code = inputs_q[14:10]; cur_pos = pos_q[50:34];  end
            3'd3: begin cur_code = inputs_q[19:15]; cur_pos = pos_q[67:51];  end
            3'd4: begin cur_code = inputs_q[24:20]; cur_pos = pos_q[84:68];  end
            3'd5: begin cur_code = inputs_q[29:25]; cur_pos = pos_q[101:85]; end
            default: ;
        endcase
    end

    // Unwrapped sums: one extra bit so a sprite running off the right or
    // bottom edge never wraps back onto visible coordinates.
    assign xs        = {1'b0, x0_q} + {6'd0, cx_q};
    assign ys        = {1'b0, y0_q} + {5'd0, cy_q};
    assign on_screen = (xs < 10'd320) && (ys < 9'd240);

    always_comb begin
        state_d  = state_q;
        inputs_d = inputs_q;
        pos_d    = pos_q;
        slot_d   = slot_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        wm1_d    = wm1_q;
        hm1_d    = hm1_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        col_d    = col_q;
        xh_d     = xh_q;
        yh_d     = yh_q;
        ch_d     = ch_q;
        plot     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    inputs_d = inputs;
                    pos_d    = pos;
                    slot_d   = 3'd0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                busy = 1'b1;
                if (cur_code[2:0] == 3'd0) begin
                    if (slot_q == 3'd5) begin
                        state_d = FINISH;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end else begin
                    x0_d  = cur_pos[16:8];
                    y0_d  = cur_pos[7:0];
                    col_d = cur_code[2:0];
                    cx_d  = 4'd0;
                    cy_d  = 4'd0;
                    case (cur_code[4:3])
                        2'b00:   begin wm1_d = 4'd3;  hm1_d = 4'd3;  end
                        2'b01:   begin wm1_d = 4'd7;  hm1_d = 4'd7;  end
                        2'b10:   begin wm1_d = 4'd15; hm1_d = 4'd15; end
                        default: begin wm1_d = 4'd15; hm1_d = 4'd3;  end
                    endcase
                    state_d = DRAW;
                end
            end
            DRAW: begin
                busy = 1'b1;
                plot = on_screen;
                if (on_screen) begin
                    xh_d = xs[8:0];
                    yh_d = ys[7:0];
                    ch_d = col_q;
                end
                if (cx_q == wm1_q) begin
                    cx_d = 4'd0;
                    if (cy_q == hm1_q) begin
                        if (slot_q == 3'd5) begin
                            state_d = FINISH;
                        end else begin
                            slot_d  = slot_q + 3'd1;
                            state_d = SETUP;
                        end
                    end else begin
                        cy_d = cy_q + 4'd1;
                    end
                end else begin
                    cx_d = cx_q + 4'd1;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Live pixel while plotting, otherwise the last plotted pixel.
    assign x      = plot ? xs[8:0] : xh_q;
    assign y      = plot ? ys[7:0] : yh_q;
    assign colour = plot ? col_q   : ch_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            inputs_q <= '0;
            pos_q    <= '0;
            slot_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            wm1_q    <= '0;
            hm1_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            col_q    <= '0;
            xh_q     <= '0;
            yh_q     <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            inputs_q <= inputs_d;
            pos_q    <= pos_d;
            slot_q   <= slot_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            wm1_q    <= wm1_d;
            hm1_q    <= hm1_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            col_q    <= col_d;
            xh_q     <= xh_d;
            yh_q     <= yh_d;
            ch_q     <= ch_d;
        end
    end

endmodule
